// File: rtl/kbd_entry_ctrl_if.sv
// Keyboard-entry bus: scan-code strobe in, memory write handshake out, status flags.
// No latency of its own; a plain bundle of wires.
// The memory side stalls the controller by holding mem_ack low.
`timescale 1ns/1ps
interface kbd_entry_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        code;
  logic              code_valid;
  logic              mem_ack;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic [2:0]        digit_cnt;
  logic              flag_enter;
  logic              ovf;
  logic              busy;

  // controller side
  modport master (
    input  code, code_valid, mem_ack,
    output mem_wr, mem_addr, mem_data, digit_cnt, flag_enter, ovf, busy
  );

  // keyboard receiver / memory side
  modport slave (
    output code, code_valid, mem_ack,
    input  mem_wr, mem_addr, mem_data, digit_cnt, flag_enter, ovf, busy
  );
endinterface

// File: rtl/kbd_entry_ctrl.sv
// Collects up to four BCD digits from PS/2 set-2 scan codes and writes them to memory on enter.
// Latency: digit visible one cycle after its strobe; mem_wr rises one cycle after enter.
// Backpressure: mem_ack low holds the write and drops all strobes; KBD_BACKSPACE_EN enables code 66.
`timescale 1ns/1ps
module kbd_entry_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  kbd_entry_ctrl_if.master bus
);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
`ifdef KBD_BACKSPACE_EN
  localparam logic [7:0] CODE_BKSP  = 8'h66;
`endif
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BRK  = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t            state;
  logic [15:0]       buffer;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] addr;
  logic              mem_wr_q;
  logic              flag_enter_q;
  logic              ovf_q;
  logic              busy_q;

  logic              is_digit;
  logic [3:0]        digit_val;

  // Translate the make code of a numeric key into its BCD value.
  always_comb begin
    is_digit  = 1'b1;
    digit_val = 4'd0;
    unique case (bus.code)
      8'h45:   digit_val = 4'd0;
      8'h16:   digit_val = 4'd1;
      8'h1E:   digit_val = 4'd2;
      8'h26:   digit_val = 4'd3;
      8'h25:   digit_val = 4'd4;
      8'h2E:   digit_val = 4'd5;
      8'h36:   digit_val = 4'd6;
      8'h3D:   digit_val = 4'd7;
      8'h3E:   digit_val = 4'd8;
      8'h46:   digit_val = 4'd9;
      default: is_digit  = 1'b0;
    endcase
  end

  // Entry FSM: the buffer doubles as the write data, so it is frozen while WR waits for ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      buffer       <= 16'h0000;
      cnt          <= 3'd0;
      addr         <= '0;
      mem_wr_q     <= 1'b0;
      flag_enter_q <= 1'b0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      flag_enter_q <= 1'b0;
      ovf_q        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.code_valid) begin
            if (bus.code == CODE_BREAK) begin
              state <= BRK;
            end else if (is_digit) begin
              if (cnt < MAX_DIGITS) begin
                buffer <= {buffer[11:0], digit_val};
                cnt    <= cnt + 3'd1;
              end else begin
                ovf_q  <= 1'b1;
              end
            end else if (bus.code == CODE_ENTER) begin
              // an empty entry is not worth a memory write
              if (cnt != 3'd0) begin
                state    <= WR;
                mem_wr_q <= 1'b1;
                busy_q   <= 1'b1;
              end
`ifdef KBD_BACKSPACE_EN
            end else if (bus.code == CODE_BKSP) begin
              // drop the most recent digit, which sits in the low nibble
              if (cnt != 3'd0) begin
                buffer <= {4'h0, buffer[15:4]};
                cnt    <= cnt - 3'd1;
              end
`endif
            end
          end
        end
        BRK: begin
          // the byte after F0 names the released key; it never acts as a press
          if (bus.code_valid) begin
            state <= IDLE;
          end
        end
        WR: begin
          // strobes arriving here, including in the ack cycle, are dropped
          if (bus.mem_ack) begin
            state        <= IDLE;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            flag_enter_q <= 1'b1;
            buffer       <= 16'h0000;
            cnt          <= 3'd0;
            addr         <= addr + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          mem_wr_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_addr   = addr;
  assign bus.mem_data   = buffer;
  assign bus.digit_cnt  = cnt;
  assign bus.flag_enter = flag_enter_q;
  assign bus.ovf        = ovf_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_kbd_entry_ctrl.sv
// Bench for kbd_entry_ctrl: directed scenarios then random scan-code traffic.
// Expected writes come from a digit-list model and are matched by a negedge monitor.
// mem_ack is driven randomly, including long hold-offs and stray acks outside a write.
`timescale 1ns/1ps
module tb_kbd_entry_ctrl;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  kbd_entry_ctrl_if #(.ADDR_W(AW)) bus ();
  kbd_entry_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t exp_q[$];

  // reference model state: the entry is just a list of digit values
  int  m_digits[$];
  bit  m_brk = 0;
  bit  m_wr = 0;
  int  m_addr = 0;
  int  m_commits = 0;
  int  m_ovf = 0;

  int  seen_flags = 0;
  int  seen_ovf = 0;
  bit  mon_prev = 0;
  wr_t mon_e;
  wr_t held;

  logic [7:0] dcodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                              8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++)
      if (dcodes[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [15:0] model_buf();
    logic [15:0] v;
    v = 16'h0;
    foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_brk  = 0;
    m_wr   = 0;
    m_addr = 0;
    exp_q.delete();
  endtask

  // apply one cycle of inputs, advance the model, and return at posedge+1
  task automatic step(input bit v, input logic [7:0] c, input bit a);
    int d;
    bus.code_valid = v;
    bus.code       = c;
    bus.mem_ack    = a;
    if (m_wr) begin
      if (a) begin
        m_wr = 0;
        m_commits++;
        m_addr = (m_addr + 1) % (1 << AW);
        m_digits.delete();
      end
    end else if (v) begin
      d = digit_of(c);
      if (m_brk) begin
        m_brk = 0;
      end else if (c == 8'hF0) begin
        m_brk = 1;
      end else if (d >= 0) begin
        if (m_digits.size() < 4) m_digits.push_back(d);
        else m_ovf++;
      end else if (c == 8'h5A) begin
        if (m_digits.size() > 0) begin
          exp_q.push_back('{addr: AW'(m_addr), data: model_buf()});
          m_wr = 1;
        end
      end
`ifdef KBD_BACKSPACE_EN
      else if (c == 8'h66) begin
        if (m_digits.size() > 0) void'(m_digits.pop_back());
      end
`endif
    end
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    bus.mem_ack    = 1'b0;
  endtask

  task automatic sync_check(input string tag);
    check({tag, "_digit_cnt"}, 32'(bus.digit_cnt), m_digits.size());
    check({tag, "_addr"}, 32'(bus.mem_addr), m_addr);
    check({tag, "_busy"}, 32'(bus.busy), 32'(m_wr));
    check({tag, "_data"}, 32'(bus.mem_data), 32'(model_buf()));
  endtask

  // scoreboard monitor: match each new write, and hold it stable until it ends
  always @(negedge clk) begin
    if (reset) begin
      mon_prev = 0;
    end else begin
      if (bus.mem_wr && !mon_prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.mem_addr, bus.mem_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
          check("wr_data", 32'(bus.mem_data), 32'(mon_e.data));
        end
        held = '{addr: bus.mem_addr, data: bus.mem_data};
      end else if (bus.mem_wr) begin
        check("wr_stable_addr", 32'(bus.mem_addr), 32'(held.addr));
        check("wr_stable_data", 32'(bus.mem_data), 32'(held.data));
      end
      check("busy_vs_wr", 32'(bus.busy), 32'(bus.mem_wr));
      if (bus.flag_enter) seen_flags++;
      if (bus.ovf) seen_ovf++;
      mon_prev = bus.mem_wr;
    end
  end

  initial begin
    logic [7:0] c;
    bit v;
    bit a;
    int pick;
    bus.code = 8'h00;
    bus.code_valid = 1'b0;
    bus.mem_ack = 1'b0;
    reset = 1'b1;
    #12;
    check("rst_mem_wr", 32'(bus.mem_wr), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_data", 32'(bus.mem_data), 0);
    check("rst_cnt", 32'(bus.digit_cnt), 0);
    check("rst_flags", 32'({bus.flag_enter, bus.ovf, bus.busy}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // three digits then enter, ack in the second write cycle
    step(1, 8'h16, 0); step(1, 8'h1E, 0); step(1, 8'h26, 0); step(1, 8'h5A, 0);
    check("s1_wr", 32'(bus.mem_wr), 1);
    check("s1_data", 32'(bus.mem_data), 32'h0123);
    check("s1_addr", 32'(bus.mem_addr), 0);
    step(0, 8'h00, 0); step(0, 8'h00, 1);
    check("s1_wr_done", 32'(bus.mem_wr), 0);
    check("s1_flag", 32'(bus.flag_enter), 1);
    check("s1_addr_next", 32'(bus.mem_addr), 1);
    check("s1_cnt", 32'(bus.digit_cnt), 0);
    step(0, 8'h00, 0);
    check("s1_flag_pulse", 32'(bus.flag_enter), 0);

    // break prefix swallows the following byte
    step(1, 8'h16, 0); step(1, 8'hF0, 0); step(1, 8'h16, 0); step(1, 8'h1E, 0); step(1, 8'h5A, 0);
    check("s2_data", 32'(bus.mem_data), 32'h0012);
    step(0, 8'h00, 1);
    sync_check("s2");

    // overflow on the fifth digit
    step(1, 8'h16, 0); step(1, 8'h1E, 0); step(1, 8'h26, 0); step(1, 8'h25, 0); step(1, 8'h2E, 0);
    check("s3_ovf", 32'(bus.ovf), 1);
    check("s3_cnt", 32'(bus.digit_cnt), 4);
    check("s3_data", 32'(bus.mem_data), 32'h1234);
    step(0, 8'h00, 0);
    check("s3_ovf_pulse", 32'(bus.ovf), 0);
    step(1, 8'h5A, 0); step(0, 8'h00, 1);

    // empty enter, then a held-off write with digits strobed during it
    step(1, 8'h5A, 0);
    check("s4_empty_enter", 32'(bus.mem_wr), 0);
    step(1, 8'h16, 0); step(1, 8'h5A, 0);
    for (int i = 0; i < 10; i++) step(1, dcodes[i], 0);
    check("s4_hold_wr", 32'(bus.mem_wr), 1);
    check("s4_hold_data", 32'(bus.mem_data), 32'h0001);
    step(1, 8'h26, 1);
    check("s4_cnt", 32'(bus.digit_cnt), 0);
    check("s4_wrap_addr", 32'(bus.mem_addr), 0);
    sync_check("s4");

    // fifth commit lands on address 0, then reset aborts a write mid-flight
    step(1, 8'h36, 0); step(1, 8'h5A, 0); step(0, 8'h00, 1);
    check("s5_addr", 32'(bus.mem_addr), 1);
    step(1, 8'h3D, 0); step(1, 8'h5A, 0);
    check("s5_wr_before_rst", 32'(bus.mem_wr), 1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("s5_async_wr", 32'(bus.mem_wr), 0);
    check("s5_async_addr", 32'(bus.mem_addr), 0);
    check("s5_async_flag", 32'(bus.flag_enter), 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    step(0, 8'h00, 0);
    check("s5_flags", seen_flags, m_commits);

    // backspace
    step(1, 8'h16, 0); step(1, 8'h1E, 0); step(1, 8'h66, 0); step(1, 8'h26, 0); step(1, 8'h5A, 0);
`ifdef KBD_BACKSPACE_EN
    check("s6_data", 32'(bus.mem_data), 32'h0013);
`else
    check("s6_data", 32'(bus.mem_data), 32'h0123);
`endif
    step(0, 8'h00, 1);
    sync_check("s6");

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      pick = $urandom_range(0, 11);
      if (pick < 6) c = dcodes[$urandom_range(0, 9)];
      else if (pick == 6) c = 8'hF0;
      else if (pick == 7) c = 8'h5A;
      else if (pick == 8) c = 8'h66;
      else if (pick == 9) c = 8'hE0;
      else c = 8'($urandom_range(0, 255));
      v = ($urandom_range(0, 3) != 0);
      a = m_wr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      step(v, c, a);
      if (i % 50 == 49) sync_check("rnd");
    end
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    sync_check("end");
    check("end_queue_empty", exp_q.size(), 0);
    check("end_flags", seen_flags, m_commits);
    check("end_ovf", seen_ovf, m_ovf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
